// File: rtl/io_switch_array.sv
// io_switch_array: configurable I/O switch between the CLB core and N_PADS pads.
// Each pad drives one of CORE_PER_PAD core outputs, selected by its configuration
// field, and has its own output enable. Pad inputs fan back into the core.
// Configuration is shifted serially into a shadow chain. It is copied to the
// active set only when a load has exactly CFG_W bits.
//
// Optional feature:
//   IOSW_SYNC_EN  when defined, the pad inputs pass through a 2-flop synchroniser
//                 before fanout (2-cycle latency). Otherwise in_s = in (comb).
//
// Ports:
//   clb_clk    clock for the programming and data paths
//   rst        asynchronous active-low reset
//   prog_en    shift enable for the configuration chain
//   prog_in    serial configuration data
//   prog_out   chain output (shadow[0])
//   core_out   core outputs, CORE_PER_PAD per pad
//   in         pad inputs
//   core_in    pad inputs replicated CORE_PER_PAD times per pad
//   out        registered pad outputs
//   pad_oe     registered pad output enables
//   cfg_valid  an active configuration has been committed
//   cfg_err    last load had the wrong bit count
//   cfg_done   one-cycle pulse after each commit attempt
module io_switch_array #(
    parameter int unsigned  N_PADS       = 8,
    parameter int unsigned  CORE_PER_PAD = 4,
    localparam int unsigned SEL_W        = $clog2(CORE_PER_PAD),
    localparam int unsigned CFG_W        = N_PADS * (SEL_W + 1)
) (
    input  logic                             clb_clk,
    input  logic                             rst,
    input  logic                             prog_en,
    input  logic                             prog_in,
    output logic                             prog_out,
    input  logic [N_PADS*CORE_PER_PAD-1:0]   core_out,
    input  logic [N_PADS-1:0]                in,
    output logic [N_PADS*CORE_PER_PAD-1:0]   core_in,
    output logic [N_PADS-1:0]                out,
    output logic [N_PADS-1:0]                pad_oe,
    output logic                             cfg_valid,
    output logic                             cfg_err,
    output logic                             cfg_done
);

    localparam int unsigned FIELD_W = SEL_W + 1;
    // Counter must reach CFG_W+1 so that over-long loads stay distinguishable.
    localparam int unsigned CNT_W   = $clog2(CFG_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   active_q, active_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic               cfg_err_q, cfg_err_d;
    logic               cfg_done_q, cfg_done_d;
    logic [N_PADS-1:0]  out_q, out_d;
    logic [N_PADS-1:0]  pad_oe_q, pad_oe_d;

    logic [N_PADS-1:0]  in_s;
    logic [N_PADS-1:0]  oe_a;
    logic [N_PADS-1:0]  data_a;
    logic               pads_live;

    // Input synchroniser or direct pass-through.
`ifdef IOSW_SYNC_EN
    logic [N_PADS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clb_clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = in;
`endif

    // Per-pad decode of the active configuration and input fanout.
    for (genvar p = 0; p < int'(N_PADS); p++) begin : g_pad
        logic [SEL_W-1:0]        sel;
        logic [CORE_PER_PAD-1:0] slice;

        assign oe_a[p]  = active_q[CFG_W-1-p*FIELD_W];
        assign sel      = active_q[CFG_W-2-p*FIELD_W -: SEL_W];
        assign slice    = core_out[p*CORE_PER_PAD +: CORE_PER_PAD];
        assign data_a[p] = slice[sel];
        assign core_in[p*CORE_PER_PAD +: CORE_PER_PAD] = {CORE_PER_PAD{in_s[p]}};
    end

    // State and datapath registers.
    always_ff @(posedge clb_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            count_q     <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_done_q  <= 1'b0;
            out_q       <= '0;
            pad_oe_q    <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            count_q     <= count_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_err_q   <= cfg_err_d;
            cfg_done_q  <= cfg_done_d;
            out_q       <= out_d;
            pad_oe_q    <= pad_oe_d;
        end
    end

    // Programming FSM: shift, count, then one commit cycle.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        count_d     = count_q;
        cfg_valid_d = cfg_valid_q;
        cfg_err_d   = cfg_err_q;
        cfg_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (prog_en) begin
                    shadow_d = {prog_in, shadow_q[CFG_W-1:1]};
                    count_d  = CNT_W'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (prog_en) begin
                    shadow_d = {prog_in, shadow_q[CFG_W-1:1]};
                    if (count_q != CNT_SAT) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // prog_en is ignored here; a new load begins from IDLE.
                if (count_q == CNT_FULL) begin
                    active_d    = shadow_q;
                    cfg_valid_d = 1'b1;
                    cfg_err_d   = 1'b0;
                end else begin
                    cfg_err_d   = 1'b1;
                end
                cfg_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pads are driven only while idle, not programming, and configured.
    always_comb begin
        pads_live = (state_q == IDLE) && !prog_en && cfg_valid_q;
        out_d     = '0;
        pad_oe_d  = '0;
        if (pads_live) begin
            out_d    = oe_a & data_a;
            pad_oe_d = oe_a;
        end
    end

    assign prog_out  = shadow_q[0];
    assign out       = out_q;
    assign pad_oe    = pad_oe_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_done  = cfg_done_q;

endmodule

// File: doc/io_switch_array.md
# io_switch_array

Parametrised I/O switch between the CLB core and N_PADS external pads, configured through the serial programming chain. It routes one of CORE_PER_PAD core outputs to each pad with a per-pad output enable, and fans pad inputs back into the core. Configuration is double-buffered: bits shift into a shadow chain, and the active configuration is committed only after a complete, correctly sized load.

## Interface
- N_PADS, 8: number of external pads.
- CORE_PER_PAD, 4: core outputs per pad. Power of two, at least 2.
- SEL_W, $clog2(CORE_PER_PAD): select width per pad. Derived; do not override.
- CFG_W, N_PADS*(SEL_W+1): configuration chain length. Derived.
- clb_clk  in  1  single clock for the programming and data paths.
- rst  in  1  asynchronous, active-low reset.
- prog_en  in  1  programming enable; shifts the chain while high.
- prog_in  in  1  serial configuration data.
- prog_out  out  1  chain output, equal to shadow[0].
- core_out  in  N_PADS*CORE_PER_PAD  core outputs. Pad p uses the slice [p*CORE_PER_PAD +: CORE_PER_PAD].
- in  in  N_PADS  pad inputs.
- core_in  out  N_PADS*CORE_PER_PAD  core inputs. core_in[p*CORE_PER_PAD +: CORE_PER_PAD] = {CORE_PER_PAD{in_s[p]}}.
- out  out  N_PADS  registered pad outputs.
- pad_oe  out  N_PADS  registered per-pad output enables.
- cfg_valid  out  1  an active configuration has been committed.
- cfg_err  out  1  the last load had the wrong bit count.
- cfg_done  out  1  one-cycle pulse after each commit attempt.

## Operation
- Shadow chain: CFG_W bits. When prog_en is high, shadow <= {prog_in, shadow[CFG_W-1:1]}, one bit per cycle.
- Field layout, in both shadow and active: pad p occupies bits [CFG_W-1-p*(SEL_W+1) -: SEL_W+1] as {oe, sel}. The last bit shifted in is pad 0's oe.
- Bit counter saturates at CFG_W+1.
- FSM states:
  - IDLE: prog_en=1 -> SHIFT. The shift happens this cycle and count <= 1.
  - SHIFT: prog_en=1 -> shift, count++ (saturating). prog_en=0 -> COMMIT with no shift.
  - COMMIT, one cycle:
    - If count==CFG_W: active <= shadow, cfg_valid <= 1, cfg_err <= 0.
    - Otherwise: active is unchanged and cfg_err <= 1.
    - In both cases cfg_done <= 1 and the FSM returns to IDLE.
- If prog_en re-asserts during COMMIT, it is ignored for that cycle. The new load starts from IDLE on the next cycle, with the counter restarted.
- Output path, registered:
  - out[p] <= (state==IDLE && !prog_en && cfg_valid && oe[p]) ? core_out[p*CORE_PER_PAD + sel[p]] : 0.
  - pad_oe[p] <= the same qualifier applied to oe[p], without the data term.
- Outputs are blanked to 0 during SHIFT and COMMIT, and in any cycle where prog_en is high.
- A failed load keeps the previous active configuration. Pads resume it after COMMIT.

## Timing
- Reset values: shadow, active, count = 0; state = IDLE; out, pad_oe, cfg_valid, cfg_err, cfg_done = 0; synchroniser flops = 0.
- Reset is asynchronous and may arrive mid-SHIFT or mid-COMMIT. Everything returns to reset values, including cfg_valid=0.
- core_out -> out latency: 1 cycle.
- Full load: CFG_W cycles with prog_en high, then one COMMIT cycle.
- cfg_done is high in the cycle after COMMIT. New active config, cfg_valid and cfg_err are visible in that same cycle. out reflects the new configuration one cycle later.
- prog_out changes one cycle after each shift. It holds value while prog_en is low.

## Configuration
- IOSW_SYNC_EN defined: in passes through a 2-flop synchroniser to give in_s (reset 0). in -> core_in latency is 2 cycles.
- IOSW_SYNC_EN undefined: in_s = in, combinational, with zero latency.

## Test plan
- Reset -> out=0, pad_oe=0, cfg_valid=0, cfg_err=0, prog_out=0.
- Load with N_PADS=8, CORE_PER_PAD=4, CFG_W=24:
  - Stimulus: shift 21 zeros, then 0, 1, 1 (pad 0 oe=1, sel=2); drop prog_en; drive core_out=32'h0000_0004.
  - Required: cfg_done pulses, cfg_valid=1, then out=8'h01 and pad_oe=8'h01.
  - Then drive core_out=0 -> out=0 one cycle later.
- Short load: valid config active, then shift 23 bits of all ones -> cfg_err=1, active unchanged, out=8'h01 still with core_out=4.
- Long load: shift 25 bits -> cfg_err=1. A following correct 24-bit load -> cfg_err=0.
- Blanking and async reset:
  - Assert prog_en with a valid config and core_out=32'hFFFF_FFFF -> out=0 from the next cycle until COMMIT is done.
  - Assert rst mid-load -> cfg_valid=0 and all outputs 0 immediately.
- Input fanout: in=8'hA5 -> core_in=32'hF0F0_0F0F.
  - With IOSW_SYNC_EN defined: appears after 2 cycles.
  - With IOSW_SYNC_EN undefined: appears in the same cycle.
